// File: rtl/read_fetch_ctrl.sv
// Read fetch controller: walks a short-read ROM backwards (idx len-1..0) and streams
// {symbol, D(i), idx, last} beats through a small output FIFO. Optional macro:
// READ_FETCH_STALL_CNT_EN adds the stall_cnt[15:0] output-backpressure counter.
module read_fetch_ctrl #(
    parameter int unsigned MAX_ADDR   = 9,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] base_addr,
    input  logic [7:0] len,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       rom_ce,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_d_i,
    input  logic [1:0] rom_read_i,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic [7:0] out_d,
    output logic [7:0] out_idx,
    output logic       out_last
`ifdef READ_FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int unsigned PW = (FIFO_DEPTH == 4) ? 2 : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [1:0] sym;
        logic [7:0] d;
        logic [7:0] idx;
        logic       last;
    } beat_t;

    state_e        state_q, state_d;
    logic [7:0]    base_q, base_d;
    logic [7:0]    idx_q, idx_d;
    logic          err_q, err_d;

    beat_t         mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] cnt_q;

    logic [8:0]    last_addr;
    logic          in_range;
    logic          start_ok;
    logic          start_zero;
    logic          start_bad;
    logic          abort_act;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          fetch;
    beat_t         push_beat;
    beat_t         head;

    // Request decode, evaluated 9-bit so base+len-1 cannot wrap past MAX_ADDR.
    always_comb begin
        last_addr  = {1'b0, base_addr} + {1'b0, len} - 9'd1;
        in_range   = (last_addr <= 9'(MAX_ADDR));
        start_ok   = start && (len != 8'd0) && in_range;
        start_zero = start && (len == 8'd0);
        start_bad  = start && (len != 8'd0) && !in_range;
    end

    // Abort outranks fetch and pop in the same cycle; the FIFO is flushed instead.
    always_comb begin
        abort_act  = abort && ((state_q == S_FETCH) || (state_q == S_DRAIN));
        fifo_full  = (cnt_q == FULL_CNT);
        fifo_empty = (cnt_q == '0);
        pop        = !fifo_empty && out_ready && !abort_act;
        fetch      = (state_q == S_FETCH) && (!fifo_full || pop) && !abort_act;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN is only entered with the idx-0 beat queued, so an empty FIFO there
    // means the last beat has already been handed off.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_FETCH;
                end else if (start_zero) begin
                    state_d = S_DONE;
                end
            end
            S_FETCH: begin
                if (abort_act) begin
                    state_d = S_IDLE;
                end else if (fetch && (idx_q == 8'd0)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_act) begin
                    state_d = S_IDLE;
                end else if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        err      = err_q;
        rom_ce   = fetch;
        rom_addr = base_q + idx_q;
    end

    always_comb begin
        base_d = base_q;
        idx_d  = idx_q;
        err_d  = (state_q == S_IDLE) && start_bad;
        if ((state_q == S_IDLE) && start_ok) begin
            base_d = base_addr;
            idx_d  = len - 8'd1;
        end else if (fetch && (idx_q != 8'd0)) begin
            idx_d = idx_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            idx_q  <= idx_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        push_beat.sym  = rom_read_i;
        push_beat.d    = rom_d_i;
        push_beat.idx  = idx_q;
        push_beat.last = (idx_q == 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (abort_act) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (fetch) begin
                mem_q[wr_ptr_q] <= push_beat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (fetch && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!fetch && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_valid = !fifo_empty;
        out_sym   = head.sym;
        out_d     = head.d;
        out_idx   = head.idx;
        out_last  = head.last;
    end

`ifdef READ_FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && (start_ok || start_zero)) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_read_fetch_ctrl.sv
// Directed bench for read_fetch_ctrl: nominal stream, backpressure, range/zero-length
// requests, abort, and mid-fetch reset, all against hand-derived cycle expectations.
module tb_read_fetch_ctrl;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] len;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;
    logic       rom_ce;
    logic [7:0] rom_addr;
    logic [7:0] rom_d_i;
    logic [1:0] rom_read_i;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic [7:0] out_d;
    logic [7:0] out_idx;
    logic       out_last;
`ifdef READ_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [1:0] rom_sym [256];
    logic [7:0] rom_dv  [256];

    int n_assert = 0;
    int n_fail   = 0;

    assign rom_read_i = rom_sym[rom_addr];
    assign rom_d_i    = rom_dv[rom_addr];

    read_fetch_ctrl #(
        .MAX_ADDR  (9),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_d_i   (rom_d_i),
        .rom_read_i(rom_read_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_d     (out_d),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef READ_FETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return {busy, done, err, rom_ce, rom_addr, out_valid, out_sym, out_d, out_idx, out_last};
    endfunction

    function automatic logic [31:0] beat_exp(input logic [1:0] s, input logic [7:0] d,
                                             input logic [7:0] i, input logic l);
        return {12'd0, 1'b1, s, d, i, l};
    endfunction

    function automatic logic [31:0] beat_obs();
        return {12'd0, out_valid, out_sym, out_d, out_idx, out_last};
    endfunction

    int  e_beat;
    int  e_fetch;
    int  occ;
    int  vcnt;
    bit  seen_done;
    bit  hs;

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a          = 8'(i);
            rom_sym[i] = a[1:0];
            rom_dv[i]  = 8'h40 + a;
        end
        rom_dv[0] = 8'd3;
        rom_dv[1] = 8'd5;
        rom_dv[2] = 8'd6;
        rom_dv[3] = 8'd9;

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_outs_t0", all_outs(), 32'd0);
        tick();
        chk("rst_outs_hold", all_outs(), 32'd0);
`ifdef READ_FETCH_STALL_CNT_EN
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk("idle_after_rst", all_outs(), 32'd0);

        // Nominal len=4 stream, out_ready high
        base_addr = 8'd0; len = 8'd4; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_n1_busy", {31'd0, busy}, 32'd1);
        chk("t1_n1_ce", {23'd0, out_valid, rom_ce, rom_addr}, {23'd0, 1'b0, 1'b1, 8'd3});
        tick();
        chk("t1_beat3", beat_obs(), beat_exp(2'd3, 8'd9, 8'd3, 1'b0));
        tick();
        chk("t1_beat2", beat_obs(), beat_exp(2'd2, 8'd6, 8'd2, 1'b0));
        tick();
        chk("t1_beat1", beat_obs(), beat_exp(2'd1, 8'd5, 8'd1, 1'b0));
        chk("t1_n4_ce", {23'd0, rom_ce, rom_addr}, {23'd0, 1'b1, 8'd0});
        tick();
        chk("t1_beat0", beat_obs(), beat_exp(2'd0, 8'd3, 8'd0, 1'b1));
        chk("t1_n5_ctl", {28'd0, busy, done, rom_ce, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("t1_n5_addr_hold", {24'd0, rom_addr}, 32'd0);
        tick();
        chk("t1_n6", {29'd0, busy, done, out_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
        tick();
        chk("t1_n7_done", {30'd0, busy, done}, {30'd0, 1'b1, 1'b1});
        tick();
        chk("t1_n8_idle", {30'd0, busy, done}, 32'd0);

        // Backpressure: base 2, len 5, out_ready low for the first 6 valid cycles
        base_addr = 8'd2; len = 8'd5; out_ready = 1'b0; start = 1'b1;
        tick();
        start     = 1'b0;
        e_beat    = 4;
        e_fetch   = 4;
        occ       = 0;
        vcnt      = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (out_valid && vcnt < 6) begin
                    out_ready = 1'b0;
                    vcnt++;
                end else begin
                    out_ready = 1'b1;
                end
                #1;
                hs = out_valid && out_ready;
                if (hs) begin
                    chk("t2_beat", beat_obs(),
                        beat_exp(rom_sym[2 + e_beat], rom_dv[2 + e_beat], 8'(e_beat), e_beat == 0));
                    e_beat--;
                end
                if (rom_ce) begin
                    chk("t2_addr", {24'd0, rom_addr}, 32'(2 + e_fetch));
                    e_fetch--;
                end
                if (occ == DEPTH && !hs) chk("t2_full_no_ce", {31'd0, rom_ce}, 32'd0);
                occ = occ + int'(rom_ce) - int'(hs);
                tick();
            end
        end
        chk("t2_done_seen", {31'd0, seen_done}, 32'd1);
        chk("t2_all_beats", e_beat, -1);
        chk("t2_all_fetches", e_fetch, -1);
`ifdef READ_FETCH_STALL_CNT_EN
        chk("t2_stall_cnt", {16'd0, stall_cnt}, 32'd6);
`endif
        tick();
        chk("t2_idle", {30'd0, busy, done}, 32'd0);

        // Out-of-range request: 8+3-1 = 10 > 9
        base_addr = 8'd8; len = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_err_pulse", {29'd0, err, busy, rom_ce}, {29'd0, 1'b1, 1'b0, 1'b0});
        tick();
        chk("t3_err_clear", {29'd0, err, busy, rom_ce}, 32'd0);

        // Zero-length request: done with no beats
        base_addr = 8'd0; len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_len0_done", {28'd0, busy, done, out_valid, rom_ce}, {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        tick();
        chk("t3_len0_idle", {28'd0, busy, done, out_valid, err}, 32'd0);

        // Upper boundary accepted: 7+3-1 = 9
        base_addr = 8'd7; len = 8'd3; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_edge_accept", {22'd0, err, busy, rom_ce, rom_addr}, {22'd0, 1'b0, 1'b1, 1'b1, 8'd9});
        wait_done("t3_edge_done", 20);
        tick();

        // Abort the cycle after the second beat of a len=8 fetch
        base_addr = 8'd0; len = 8'd8; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t4_beat7", beat_obs(), beat_exp(rom_sym[7], rom_dv[7], 8'd7, 1'b0));
        tick();
        chk("t4_beat6", beat_obs(), beat_exp(rom_sym[6], rom_dv[6], 8'd6, 1'b0));
        tick();
        abort = 1'b1;
        #1;
        chk("t4_abort_no_ce", {31'd0, rom_ce}, 32'd0);
        chk("t4_abort_head", beat_obs(), beat_exp(rom_sym[5], rom_dv[5], 8'd5, 1'b0));
        tick();
        abort = 1'b0;
        chk("t4_flushed", {29'd0, out_valid, busy, done}, 32'd0);
        base_addr = 8'd0; len = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart", {22'd0, out_valid, busy, rom_ce, rom_addr}, {22'd0, 1'b0, 1'b1, 1'b1, 8'd3});
        wait_done("t4_restart_done", 20);
        tick();

        // Reset mid-fetch with two beats buffered
        base_addr = 8'd0; len = 8'd8; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t5_buffered", {30'd0, out_valid, busy}, {30'd0, 1'b1, 1'b1});
        rst = 1'b1;
        #1;
        chk("t5_rst_outs", all_outs(), 32'd0);
        tick();
        chk("t5_rst_hold", all_outs(), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_post_idle", {27'd0, busy, done, err, rom_ce, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/read_fetch_ctrl.md
READ_FETCH_CTRL -- requirements
Module: read_fetch_ctrl

Interface
REQ-001 Parameter MAX_ADDR, default 9, is the last valid short-read ROM word address.
REQ-002 Parameter FIFO_DEPTH, default 2, sets output buffer entries; legal values are 2 or 4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to fetch a read; sampled only in IDLE.
REQ-006 base_addr  input  8  ROM address of symbol index 0; sampled with start.
REQ-007 len  input  8  number of symbols; sampled with start.
REQ-008 abort  input  1  cancels an active fetch.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse when a fetch completes normally.
REQ-011 err  output  1  one-cycle pulse when a start is rejected.
REQ-012 rom_ce  output  1  ROM chip enable.
REQ-013 rom_addr  output  8  ROM address.
REQ-014 rom_d_i  input  8  ROM search bound D(i), combinational from rom_addr.
REQ-015 rom_read_i  input  2  ROM symbol (00 A, 01 C, 10 G, 11 T), combinational.
REQ-016 out_valid  output  1  output beat valid.
REQ-017 out_ready  input  1  downstream accepts the beat.
REQ-018 out_sym  output  2  symbol for the beat.
REQ-019 out_d  output  8  D(i) for the beat.
REQ-020 out_idx  output  8  symbol index i for the beat.
REQ-021 out_last  output  1  high on the beat with index 0.

Function
REQ-022 FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE -> FETCH: start with len!=0 and base_addr+len-1 <= MAX_ADDR, computed 9-bit.
- IDLE -> DONE: start with len==0.
- start in IDLE with an out-of-range request: err pulses the next cycle and the FSM stays in IDLE.
REQ-023 FETCH issues indices in descending order len-1 down to 0, which is backward-search order, with rom_addr = base_addr + idx.
REQ-024 A fetch fires in a cycle where the state is FETCH and the FIFO is not full, or is full with a pop in the same cycle.
- On a fetch, rom_ce=1 and {rom_read_i, rom_d_i, idx, idx==0} are pushed at the clock edge.
- In all other cycles rom_ce=0 and rom_addr holds its value.
REQ-025 FETCH -> DRAIN after the idx 0 fetch.
REQ-026 DRAIN -> DONE when the FIFO is empty after the out_last handshake.
REQ-027 DONE -> IDLE after one cycle; done=1 while in DONE.
REQ-028 Output is a FIFO_DEPTH-entry FIFO.
- out_valid = FIFO non-empty; out_* show the head entry.
- A pop occurs when out_valid & out_ready.
- out_* are stable while out_valid=1 and out_ready=0.
REQ-029 Latency: start at edge N gives the first rom_ce in cycle N+1 and the first out_valid in cycle N+2.
- With out_ready held high, one beat per cycle; done occurs two cycles after the last-beat handshake.
REQ-030 abort in FETCH or DRAIN:
- flushes the FIFO at the next edge (out_valid=0);
- goes to IDLE without done;
- has priority over a same-cycle fetch or pop.
- abort is ignored in IDLE and DONE.
REQ-031 start while busy=1 is ignored; err does not pulse.
REQ-032 Simultaneous push and pop on a full FIFO leaves occupancy unchanged; no push is lost.

Reset
REQ-033 While rst=1, all state clears asynchronously: FSM=IDLE, FIFO empty, busy=0, done=0, err=0, rom_ce=0, rom_addr=0, out_valid=0, out_sym=0, out_d=0, out_idx=0, out_last=0.
REQ-034 rst asserted mid-fetch discards all beats; no done is produced.

Configuration
REQ-035 Macro READ_FETCH_STALL_CNT_EN.
- When defined, adds output stall_cnt[15:0]: counts cycles with out_valid=1 and out_ready=0, clears on an accepted start, saturates at 16'hFFFF, and resets to 0.
- When undefined, the port and its logic are absent and the block is otherwise identical.

Verification
REQ-036 base_addr=0, len=4, out_ready=1, ROM words 0..3 = {A,3},{C,5},{G,6},{T,9}: beats are (T,9,idx3), (G,6,2), (C,5,1), (A,3,0,last); first out_valid at cycle N+2; done at cycle N+7.
REQ-037 base_addr=2, len=5, out_ready low for 6 cycles after the first out_valid: at most FIFO_DEPTH beats are buffered; rom_ce=0 while full; the beat sequence (idx 4..0 at addr 6..2) is correct and complete.
REQ-038 base_addr=8, len=3 (8+2=10>9): err pulses once; busy stays 0; rom_ce never asserts. len=0: done pulses with no beats.
REQ-039 abort asserted the cycle after the second beat of a len=8 fetch: out_valid=0 and busy=0 the next cycle; no done; a new start is accepted immediately.
REQ-040 rst asserted mid-fetch with 2 beats buffered: all outputs are 0 during reset; after release the block idles until start. With READ_FETCH_STALL_CNT_EN, the REQ-037 run gives stall_cnt=6.
